// File: rtl/mer_meter.sv
// Modulation-error-ratio meter for 4-ASK: slices each captured symbol, squares the slicer
// error and averages error power and symbol magnitude over 2^LOG2_SYMS symbols.
module mer_meter #(
    parameter int DATA_WIDTH = 18,
    parameter int LOG2_SYMS  = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clk_en,
    input  logic                           start,
    input  logic signed [DATA_WIDTH-1:0]   ref_level,
    input  logic signed [DATA_WIDTH-1:0]   decision_variable,
    output logic                           busy,
    output logic                           done,
    output logic        [2*DATA_WIDTH-1:0] err_power,
    output logic        [DATA_WIDTH-1:0]   avg_mag,
    output logic        [1:0]              state_dbg
);

    localparam int SQW = 2*DATA_WIDTH + LOG2_SYMS;
    localparam int MGW = DATA_WIDTH + LOG2_SYMS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   flush_q, flush_d;
    logic   capture, clear, load;

    logic [LOG2_SYMS-1:0] cnt_q, cnt_d;

    logic signed [DATA_WIDTH-1:0] dv1_q;
    logic                         v1_q;

    logic [2*DATA_WIDTH-1:0] sq2_q;
    logic [DATA_WIDTH-1:0]   mag2_q;
    logic                    v2_q;

    logic [SQW-1:0] sq_acc_q;
    logic [MGW-1:0] mag_acc_q;

    logic [2*DATA_WIDTH-1:0] err_power_q;
    logic [DATA_WIDTH-1:0]   avg_mag_q;
    logic                    done_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    cnt_d   = '0;
                end
            end
            S_ACCUM: begin
                if (clk_en) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == {LOG2_SYMS{1'b1}}) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Two cycles let the last sample drain through stages 2 and 3.
                flush_d = ~flush_q;
                if (flush_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy    = (state_q != S_IDLE);
        capture = (state_q == S_ACCUM) && clk_en;
        clear   = (state_q == S_IDLE) && start;
        load    = (state_q == S_DONE);
    end

    assign state_dbg = state_q;

    // ---------------- Stage 1: sample capture ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dv1_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            v1_q <= capture;
            if (capture) dv1_q <= decision_variable;
        end
    end

    // ---------------- Stage 2: slicer, error square, magnitude ----------------
    logic signed [DATA_WIDTH:0] a_x, two_a, three_a, dv_x, s_lvl, err;
    logic [DATA_WIDTH-1:0]      err_abs, dv_abs;
    logic [2*DATA_WIDTH-1:0]    ea_x, err_sq;

    always_comb begin
        a_x     = {ref_level[DATA_WIDTH-1], ref_level};
        two_a   = a_x <<< 1;
        three_a = two_a + a_x;
        dv_x    = {dv1_q[DATA_WIDTH-1], dv1_q};
        if (dv_x >= two_a)       s_lvl = three_a;
        else if (dv_x >= 0)      s_lvl = a_x;
        else if (dv_x >= -two_a) s_lvl = -a_x;
        else                     s_lvl = -three_a;
        err = dv_x - s_lvl;
        // |err| < 2^(DATA_WIDTH-1) because 3a is below full scale.
        err_abs = err[DATA_WIDTH] ? DATA_WIDTH'(-err) : DATA_WIDTH'(err);
        ea_x    = {{DATA_WIDTH{1'b0}}, err_abs};
        err_sq  = ea_x * ea_x;
        dv_abs  = dv1_q[DATA_WIDTH-1] ? $unsigned(-dv1_q) : $unsigned(dv1_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sq2_q  <= '0;
            mag2_q <= '0;
            v2_q   <= 1'b0;
        end else begin
            sq2_q  <= err_sq;
            mag2_q <= dv_abs;
            v2_q   <= v1_q;
        end
    end

    // ---------------- Stage 3: accumulators ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sq_acc_q  <= '0;
            mag_acc_q <= '0;
        end else if (clear) begin
            sq_acc_q  <= '0;
            mag_acc_q <= '0;
        end else if (v2_q) begin
            sq_acc_q  <= sq_acc_q + {{LOG2_SYMS{1'b0}}, sq2_q};
            mag_acc_q <= mag_acc_q + {{LOG2_SYMS{1'b0}}, mag2_q};
        end
    end

    // ---------------- Result registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_power_q <= '0;
            avg_mag_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= load;
            if (load) begin
                err_power_q <= (2*DATA_WIDTH)'(sq_acc_q >> LOG2_SYMS);
                avg_mag_q   <= DATA_WIDTH'(mag_acc_q >> LOG2_SYMS);
            end
        end
    end

    assign err_power = err_power_q;
    assign avg_mag   = avg_mag_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mer_meter.sv
// Directed bench for mer_meter: stimulus pushes expected results, a done-driven
// monitor pops and compares them.
module tb_mer_meter;

    localparam int DW = 18;
    localparam int L  = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   clk_en;
    logic                   start;
    logic signed [DW-1:0]   ref_level;
    logic signed [DW-1:0]   dv;
    logic                   busy;
    logic                   done;
    logic [2*DW-1:0]        err_power;
    logic [DW-1:0]          avg_mag;
    logic [1:0]             state_dbg;

    mer_meter #(.DATA_WIDTH(DW), .LOG2_SYMS(L)) dut (
        .clk               (clk),
        .reset             (reset),
        .clk_en            (clk_en),
        .start             (start),
        .ref_level         (ref_level),
        .decision_variable (dv),
        .busy              (busy),
        .done              (done),
        .err_power         (err_power),
        .avg_mag           (avg_mag),
        .state_dbg         (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [3*DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int last_en  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                logic [3*DW-1:0] e;
                e = exp_q.pop_front();
                check("err_power", {28'd0, err_power}, {28'd0, e[3*DW-1:DW]});
                check("avg_mag",   {46'd0, avg_mag},   {46'd0, e[DW-1:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic signed [DW-1:0] v, input logic en, input logic rec);
        clk_en = en;
        dv     = v;
        if (rec) last_en = cyc;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic measure(input logic signed [DW-1:0] v0, input logic signed [DW-1:0] v1,
                           input int n0, input int gap, input int extra, input bit mid_start,
                           input bit start_in_done,
                           input logic [2*DW-1:0] ep, input logic [DW-1:0] am);
        int t;
        exp_q.push_back({ep, am});
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            repeat (gap) drive('0, 1'b0, 1'b0);
            start = mid_start && (i == 8);
            drive((i < n0) ? v0 : v1, 1'b1, 1'b1);
            start = 1'b0;
        end
        // Enables past the last capture must not be accumulated.
        for (int i = 0; i < extra; i++) drive(-18'sd100000, 1'b1, 1'b0);
        drive('0, 1'b0, 1'b0);
        t = 0;
        while (!done && t < 64) begin
            start = start_in_done && (state_dbg == 2'd3);
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        if (!done) begin
            check("done_timeout", {63'd0, done}, 64'd1);
        end else begin
            check("latency", 64'(cyc - last_en), 64'd4);
            check("busy_at_done", {63'd0, busy}, 64'd0);
        end
        @(negedge clk);
        if (start_in_done) check("start_in_done_ignored", {63'd0, busy}, 64'd0);
        check("done_pulse_width", {63'd0, done}, 64'd0);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        clk_en    = 1'b0;
        start     = 1'b0;
        ref_level = 18'sd16384;
        dv        = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",      {63'd0, busy},      64'd0);
        check("reset_done",      {63'd0, done},      64'd0);
        check("reset_err_power", {28'd0, err_power}, 64'd0);
        check("reset_avg_mag",   {46'd0, avg_mag},   64'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_reset", {63'd0, busy}, 64'd0);

        // Constant error inside the +a decision region.
        measure(18'sd24576, 18'sd24576, 16, 15, 0, 1'b0, 1'b0, 36'd67108864, 18'd24576);
        // dv = 2a slices up to 3a.
        measure(18'sd32768, 18'sd32768, 16, 15, 0, 1'b0, 1'b0, 36'd268435456, 18'd32768);
        // Error-free negative symbols.
        measure(-18'sd16384, -18'sd49152, 8, 15, 0, 1'b0, 1'b0, 36'd0, 18'd32768);
        // Back-to-back enables, trailing enables, start held in DONE.
        measure(18'sd24576, 18'sd24576, 16, 0, 2, 1'b0, 1'b1, 36'd67108864, 18'd24576);
        // -2a vs just below -2a; both averages truncate a .5 remainder.
        measure(-18'sd32768, -18'sd32769, 8, 15, 0, 1'b0, 1'b0, 36'd268419072, 18'd32768);

        // Reset in the middle of a measurement.
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            repeat (15) drive('0, 1'b0, 1'b0);
            drive(18'sd24576, 1'b1, 1'b0);
        end
        repeat (3) drive('0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("midreset_busy",      {63'd0, busy},      64'd0);
        check("midreset_err_power", {28'd0, err_power}, 64'd0);
        check("midreset_avg_mag",   {46'd0, avg_mag},   64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("quiet_after_reset", {63'd0, busy}, 64'd0);

        // Start pulsed during ACCUM must not restart the measurement.
        measure(18'sd16384, 18'sd16384, 16, 15, 0, 1'b1, 1'b0, 36'd0, 18'd16384);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mer_meter.md
MER_METER -- requirements
Module: mer_meter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18: width of the decision variable, signed 1s17 format.
REQ-002 SHALL have parameter LOG2_SYMS, default 10: each measurement averages 2^LOG2_SYMS symbols.
REQ-003 SHALL have port clk, input, 1: system clock; the block has one clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port clk_en, input, 1: symbol-rate enable, one clk wide.
REQ-006 SHALL have port start, input, 1: starts one measurement, sampled on clk.
REQ-007 SHALL have port ref_level, input, DATA_WIDTH signed: 4-ASK inner level a, where 0 < 3a < 2^(DATA_WIDTH-1).
REQ-008 SHALL have port decision_variable, input, DATA_WIDTH signed: received symbol, valid on clk_en.
REQ-009 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1: one-clk pulse when the results update.
REQ-011 SHALL have port err_power, output, 2*DATA_WIDTH unsigned: mean squared slicer error, integer scale.
REQ-012 SHALL have port avg_mag, output, DATA_WIDTH unsigned: mean |decision_variable|.

Function
REQ-013 SHALL implement the FSM states IDLE, ACCUM, FLUSH and DONE.
REQ-014 In IDLE, start=1 SHALL clear both accumulators and the symbol counter and enter ACCUM on the next clk.
REQ-015 start SHALL be ignored in ACCUM, FLUSH and DONE, with no restart and no effect on the results.
REQ-016 In ACCUM, each clk_en=1 SHALL capture decision_variable into the stage-1 register with valid=1 and increment the counter; the first clk_en counted is the first one seen in ACCUM.
REQ-017 After 2^LOG2_SYMS captures the FSM SHALL enter FLUSH; no further samples are captured.
REQ-018 Stage 2 SHALL register, every clk, the slicer output s from the stage-1 sample.
- Slicer rule for stage 2: s = 3a if dv >= 2a; s = a if 0 <= dv < 2a; s = -a if -2a <= dv < 0; s = -3a if dv < -2a.
- Stage 2 also registers err = dv - s (DATA_WIDTH+1 signed), err^2 (2*DATA_WIDTH unsigned) and |dv| (DATA_WIDTH unsigned), plus valid.
REQ-019 Stage 3 SHALL add err^2 into a 2*DATA_WIDTH+LOG2_SYMS accumulator and |dv| into a DATA_WIDTH+LOG2_SYMS accumulator on each valid clk; neither accumulator can overflow and no saturation is applied.
REQ-020 Each valid flag SHALL be cleared one clk after it is consumed, so each sample is accumulated exactly once regardless of clk_en spacing, including clk_en held high continuously.
REQ-021 FLUSH SHALL last exactly 2 clk cycles and then enter DONE.
REQ-022 In DONE, for exactly one clk, the block SHALL:
- load err_power = sq_acc >> LOG2_SYMS (truncating);
- load avg_mag = mag_acc >> LOG2_SYMS (truncating);
- assert done;
- return to IDLE on the next clk.
REQ-023 err_power and avg_mag SHALL hold their values until the next DONE.
REQ-024 Latency from the last captured clk_en to done SHALL be exactly 4 clk cycles.
REQ-025 A start pulse in the same clk as DONE SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-026 ref_level SHALL be sampled continuously and is required to be stable from start until done.

Reset
REQ-027 reset=1 SHALL, asynchronously and at any time including mid-measurement:
- force the state to IDLE;
- clear the counter, both accumulators, all pipeline registers and valid flags;
- set busy=0, done=0, err_power=0 and avg_mag=0.
REQ-028 After reset is released, the block SHALL do nothing until a new start.

Verification
REQ-029 Bench setup: DATA_WIDTH=18, LOG2_SYMS=4, ref_level=16384, clk_en every 16th clk.
REQ-030 Constant error: 16 symbols dv=24576 -> err_power=67108864, avg_mag=24576, done 4 clk after the 16th enable, busy high from the cycle after start until DONE.
REQ-031 Slicer boundary: 16 symbols dv=32768 (=2a) -> s=49152, err=-16384, err_power=268435456, avg_mag=32768.
REQ-032 Negative and mixed symbols: 8 symbols dv=-16384 plus 8 symbols dv=-49152 (error-free) -> err_power=0, avg_mag=32768.
REQ-033 Back-to-back enables: clk_en held high for 16 clk with dv=24576 -> identical results to REQ-030; exactly 16 samples are accumulated.
REQ-034 Reset during measurement: assert reset after the 7th enable -> busy=0, err_power=0, avg_mag=0 immediately.
- A following start with 16 symbols dv=16384 gives err_power=0 and avg_mag=16384.
- A start pulsed during ACCUM does not shorten or restart the measurement.
